// File: rtl/systolic_skew_feeder_8x8.sv
// Skewed A/B edge feeder for an 8x8 output-stationary systolic array.
// Latency: a beat accepted at cycle t reaches lane i after i+1 advances (t+i+1 with no bubbles).
// Backpressure: in_ready is high only in STREAM; bubbles freeze every skew chain and drop arr_en.
module systolic_skew_feeder_8x8 #(
  parameter int data_width = 8,
  parameter int N          = 8,
  parameter int flush_len  = 2*N-1,
  parameter int cnt_width  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [N*data_width-1:0] a_vec,
  input  logic [N*data_width-1:0] b_vec,
  output logic [N*data_width-1:0] a_skew_flat,
  output logic [N*data_width-1:0] b_skew_flat,
  output logic                    arr_en,
  output logic                    acc_clr,
  output logic                    busy,
  output logic                    done,
  output logic [cnt_width-1:0]    k_count
);

  localparam int FW = $clog2(flush_len + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               state_q;
  logic [FW-1:0]        flush_cnt_q;
  logic                 in_ready_q;
  logic                 arr_en_q;
  logic                 acc_clr_q;
  logic                 busy_q;
  logic                 done_q;
  logic [cnt_width-1:0] k_count_q;

  logic advance;
  logic flushing;

  // Chains move on an accepted beat or on every flush cycle; flush cycles inject zeros.
  assign flushing = (state_q == S_FLUSH);
  assign advance  = ((state_q == S_STREAM) && in_valid) || flushing;

  // Job control FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= '0;
      in_ready_q  <= 1'b0;
      arr_en_q    <= 1'b0;
      acc_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      k_count_q   <= '0;
    end else begin
      acc_clr_q <= 1'b0;
      done_q    <= 1'b0;
      arr_en_q  <= advance;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_STREAM;
            acc_clr_q  <= 1'b1;
            k_count_q  <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_STREAM: begin
          if (in_valid) begin
            if (k_count_q != {cnt_width{1'b1}}) begin
              k_count_q <= k_count_q + 1'b1;
            end
            if (in_last) begin
              state_q     <= S_FLUSH;
              in_ready_q  <= 1'b0;
              flush_cnt_q <= FW'(flush_len);
            end
          end
        end
        S_FLUSH: begin
          flush_cnt_q <= flush_cnt_q - 1'b1;
          if (flush_cnt_q == FW'(1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign arr_en   = arr_en_q;
  assign acc_clr  = acc_clr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign k_count  = k_count_q;

  // Lane i gets an (i+1)-deep chain so lane i lags lane 0 by i advances.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [data_width-1:0] a_d;
    logic [data_width-1:0] b_d;
    logic [data_width-1:0] a_q [0:i];
    logic [data_width-1:0] b_q [0:i];

    assign a_d = flushing ? '0 : a_vec[i*data_width +: data_width];
    assign b_d = flushing ? '0 : b_vec[i*data_width +: data_width];

    // Shift the lane's chain on advance; otherwise every stage holds.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s <= i; s++) begin
          a_q[s] <= '0;
          b_q[s] <= '0;
        end
      end else if (advance) begin
        a_q[0] <= a_d;
        b_q[0] <= b_d;
        for (int s = 1; s <= i; s++) begin
          a_q[s] <= a_q[s-1];
          b_q[s] <= b_q[s-1];
        end
      end
    end

    assign a_skew_flat[i*data_width +: data_width] = a_q[i];
    assign b_skew_flat[i*data_width +: data_width] = b_q[i];
  end

endmodule
